// File: rtl/cdb_arbiter_if.sv
// Packet type and request/broadcast bundle for the common-data-bus arbiter.
// Requesters drive the master side; the arbiter owns the slave side.
package cdb_pkg;

   typedef struct packed {
      logic        valid;
      logic [3:0]  rob_entry;
      logic [31:0] data;
      logic        is_branch;
      logic        branch_taken;
      logic [31:0] branch_target;
   } cdb_packet_s;

endpackage

interface cdb_arbiter_if #(
   parameter int N_REQ = 4
);
   import cdb_pkg::*;

   logic                   flush_i;
   logic [N_REQ-1:0]       req_valid_i;
   logic [N_REQ-1:0][31:0] req_data_i;
   logic [N_REQ-1:0][3:0]  req_rob_entry_i;
   logic [N_REQ-1:0]       req_is_branch_i;
   logic [N_REQ-1:0]       req_branch_taken_i;
   logic [N_REQ-1:0][31:0] req_branch_target_i;
   logic [N_REQ-1:0]       req_ready_o;
   cdb_packet_s            cdb_packet_o;
   logic [15:0]            conflict_cnt_o;

   modport master (
      output flush_i,
      output req_valid_i,
      output req_data_i,
      output req_rob_entry_i,
      output req_is_branch_i,
      output req_branch_taken_i,
      output req_branch_target_i,
      input  req_ready_o,
      input  cdb_packet_o,
      input  conflict_cnt_o
   );

   modport slave (
      input  flush_i,
      input  req_valid_i,
      input  req_data_i,
      input  req_rob_entry_i,
      input  req_is_branch_i,
      input  req_branch_taken_i,
      input  req_branch_target_i,
      output req_ready_o,
      output cdb_packet_o,
      output conflict_cnt_o
   );

endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting one functional-unit result per cycle onto the
// common data bus, with a registered broadcast and a saturating conflict counter.
module cdb_arbiter #(
   parameter int N_REQ = 4
) (
   input logic          clk_i,
   input logic          reset_i,
   cdb_arbiter_if.slave bus
);
   import cdb_pkg::*;

   localparam int             PTR_W   = $clog2(N_REQ);
   localparam logic [PTR_W:0] N_REQ_W = (PTR_W + 1)'(N_REQ);

   // One extra bit of headroom so ptr + offset never overflows before the wrap.
   function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W:0] raw);
      logic [PTR_W:0] adj;
      if (raw >= N_REQ_W) begin
         adj = raw - N_REQ_W;
      end else begin
         adj = raw;
      end
      return adj[PTR_W-1:0];
   endfunction

   function automatic logic [3:0] popcount(input logic [N_REQ-1:0] vec);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int i = 0; i < N_REQ; i++) begin
         cnt = cnt + {3'd0, vec[i]};
      end
      return cnt;
   endfunction

   logic [PTR_W-1:0] rr_ptr_r;
   cdb_packet_s      packet_r;
   logic [15:0]      conflict_cnt_r;

   logic             grant_any_s;
   logic [PTR_W-1:0] grant_idx_s;
   logic [N_REQ-1:0] ready_s;
   logic [PTR_W-1:0] next_ptr_s;
   cdb_packet_s      grant_pkt_s;
   logic             conflict_s;

   // Round-robin search starting at rr_ptr; reset and flush suppress any grant.
   always_comb begin : grant_search
      logic [PTR_W-1:0] cand;
      grant_any_s = 1'b0;
      grant_idx_s = '0;
      cand        = '0;
      if (!reset_i && !bus.flush_i) begin
         for (int k = 0; k < N_REQ; k++) begin
            cand = wrap_idx({1'b0, rr_ptr_r} + (PTR_W + 1)'(k));
            if (!grant_any_s && bus.req_valid_i[cand]) begin
               grant_any_s = 1'b1;
               grant_idx_s = cand;
            end else begin
               grant_any_s = grant_any_s;
            end
         end
      end else begin
         grant_any_s = 1'b0;
      end
   end

   // One-hot ready, next pointer and the packet to latch for the winner.
   always_comb begin
      ready_s     = '0;
      next_ptr_s  = rr_ptr_r;
      grant_pkt_s = '0;
      if (grant_any_s) begin
         ready_s[grant_idx_s]      = 1'b1;
         next_ptr_s                = wrap_idx({1'b0, grant_idx_s} + (PTR_W + 1)'(1));
         grant_pkt_s.valid         = 1'b1;
         grant_pkt_s.rob_entry     = bus.req_rob_entry_i[grant_idx_s];
         grant_pkt_s.data          = bus.req_data_i[grant_idx_s];
         grant_pkt_s.is_branch     = bus.req_is_branch_i[grant_idx_s];
         grant_pkt_s.branch_taken  = bus.req_branch_taken_i[grant_idx_s];
         grant_pkt_s.branch_target = bus.req_branch_target_i[grant_idx_s];
      end else begin
         ready_s     = '0;
         grant_pkt_s = '0;
      end
   end

   // Conflicts are only counted on cycles that are not flushed.
   always_comb begin
      conflict_s = 1'b0;
      if (!bus.flush_i && (popcount(bus.req_valid_i) >= 4'd2)) begin
         conflict_s = 1'b1;
      end else begin
         conflict_s = 1'b0;
      end
   end

   // Round-robin pointer advances past the winner; holds when nothing is granted.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rr_ptr_r <= '0;
      end else if (grant_any_s) begin
         rr_ptr_r <= next_ptr_s;
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

   // Broadcast register: granted packet for exactly one cycle, zeros otherwise.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         packet_r <= '0;
      end else if (grant_any_s) begin
         packet_r <= grant_pkt_s;
      end else begin
         packet_r <= '0;
      end
   end

   // Saturating conflict counter.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         conflict_cnt_r <= 16'd0;
      end else if (conflict_s && (conflict_cnt_r != 16'hFFFF)) begin
         conflict_cnt_r <= conflict_cnt_r + 16'd1;
      end else begin
         conflict_cnt_r <= conflict_cnt_r;
      end
   end

   assign bus.req_ready_o    = ready_s;
   assign bus.cdb_packet_o   = packet_r;
   assign bus.conflict_cnt_o = conflict_cnt_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: grants and counter checked inline, broadcast
// packets checked by a scoreboard monitor against a queue of expected packets.
module tb_cdb_arbiter;
   import cdb_pkg::*;

   localparam int N = 4;

   logic clk = 1'b0;
   logic reset_i;
   always #5 clk = ~clk;

   logic                   t_flush;
   logic [N-1:0]           t_valid;
   logic [N-1:0][31:0]     t_data;
   logic [N-1:0][3:0]      t_rob;
   logic [N-1:0]           t_isbr;
   logic [N-1:0]           t_taken;
   logic [N-1:0][31:0]     t_tgt;

   cdb_arbiter_if #(.N_REQ(N)) bus ();

   assign bus.flush_i             = t_flush;
   assign bus.req_valid_i         = t_valid;
   assign bus.req_data_i          = t_data;
   assign bus.req_rob_entry_i     = t_rob;
   assign bus.req_is_branch_i     = t_isbr;
   assign bus.req_branch_taken_i  = t_taken;
   assign bus.req_branch_target_i = t_tgt;

   cdb_arbiter #(.N_REQ(N)) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .bus     (bus)
   );

   typedef struct {
      int          cyc;
      cdb_packet_s pkt;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic cdb_packet_s exp_pkt(input int i);
      cdb_packet_s p;
      p.valid         = 1'b1;
      p.rob_entry     = t_rob[i];
      p.data          = t_data[i];
      p.is_branch     = t_isbr[i];
      p.branch_taken  = t_taken[i];
      p.branch_target = t_tgt[i];
      return p;
   endfunction

   function automatic int oh_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) begin
         if (v[i]) return i;
      end
      return 0;
   endfunction

   // At the falling edge: check grant and counter, queue the expected packet for next cycle.
   task automatic cyc_chk(input string name, input logic [N-1:0] exp_ready, input logic [15:0] exp_cnt);
      exp_t e;
      @(negedge clk);
      chk({name, " ready"}, 32'(bus.req_ready_o), 32'(exp_ready));
      chk({name, " cnt"}, 32'(bus.conflict_cnt_o), 32'(exp_cnt));
      if (exp_ready != '0) begin
         e.cyc = cyc + 1;
         e.pkt = exp_pkt(oh_idx(exp_ready));
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every valid broadcast must match the oldest expected packet.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         total++;
         bad++;
         $display("FAIL cdb missing: got no packet expected %h at cycle %0d", exp_q[0].pkt, exp_q[0].cyc);
         void'(exp_q.pop_front());
      end
      if (bus.cdb_packet_o.valid === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL cdb unexpected: got %h expected no packet (cycle %0d)", bus.cdb_packet_o, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (bus.cdb_packet_o !== e.pkt || e.cyc != cyc) begin
               bad++;
               $display("FAIL cdb packet: got %h at cycle %0d expected %h at cycle %0d",
                        bus.cdb_packet_o, cyc, e.pkt, e.cyc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      reset_i = 1'b1;
      t_flush = 1'b0;
      t_valid = '0;
      t_isbr  = '0;
      t_taken = '0;
      for (int i = 0; i < N; i++) begin
         t_data[i] = 32'h1000_0000 + 32'(i);
         t_rob[i]  = 4'(i + 1);
         t_tgt[i]  = 32'h0000_0000;
      end
      @(posedge clk);
      #1;

      // Reset beats requests
      t_valid = 4'b1111;
      cyc_chk("reset_req", 4'b0000, 16'd0);
      t_valid = '0;
      reset_i = 1'b0;

      for (int i = 0; i < 5; i++) begin
         chk("idle valid", 32'(bus.cdb_packet_o.valid), 32'd0);
         cyc_chk("idle", 4'b0000, 16'd0);
      end

      // Single request from requester 2
      t_data[2] = 32'hDEAD_BEEF;
      t_rob[2]  = 4'd5;
      t_valid   = 4'b0100;
      cyc_chk("single", 4'b0100, 16'd0);
      t_valid   = '0;
      cyc_chk("single_t1", 4'b0000, 16'd0);
      chk("single_t2 valid", 32'(bus.cdb_packet_o.valid), 32'd0);

      // Pointer now 3: with everyone valid requester 3 wins
      t_valid = 4'b1111;
      cyc_chk("ptr_is_3", 4'b1000, 16'd0);
      reset_i = 1'b1;
      cyc_chk("reset_mid", 4'b0000, 16'd1);
      reset_i = 1'b0;
      chk("after_reset valid", 32'(bus.cdb_packet_o.valid), 32'd0);

      // All four held from reset
      cyc_chk("rr0", 4'b0001, 16'd0);
      cyc_chk("rr1", 4'b0010, 16'd1);
      cyc_chk("rr2", 4'b0100, 16'd2);
      cyc_chk("rr3", 4'b1000, 16'd3);
      cyc_chk("rr4", 4'b0001, 16'd4);
      t_valid = '0;
      cyc_chk("drain", 4'b0000, 16'd5);

      // Pointer 1, requesters 0 and 3
      t_valid = 4'b1001;
      cyc_chk("wrap_a", 4'b1000, 16'd5);
      t_valid = 4'b0001;
      cyc_chk("wrap_b", 4'b0001, 16'd6);
      t_valid = '0;

      // Branch result from requester 3
      t_data[3]  = 32'h0000_ABCD;
      t_rob[3]   = 4'd9;
      t_isbr[3]  = 1'b1;
      t_taken[3] = 1'b1;
      t_tgt[3]   = 32'h0000_0100;
      t_valid    = 4'b1000;
      cyc_chk("branch", 4'b1000, 16'd6);

      // Flush right after a grant: no grant now, earlier packet still broadcast
      t_valid = 4'b0111;
      t_flush = 1'b1;
      cyc_chk("flush", 4'b0000, 16'd6);
      t_flush = 1'b0;
      chk("post_flush valid", 32'(bus.cdb_packet_o.valid), 32'd0);
      cyc_chk("post_flush", 4'b0001, 16'd6);
      t_valid = 4'b0110;
      cyc_chk("after_flush", 4'b0010, 16'd7);
      t_valid = '0;
      cyc_chk("idle2", 4'b0000, 16'd8);

      // Saturation
      force dut.conflict_cnt_r = 16'hFFFD;
      #1;
      release dut.conflict_cnt_r;
      t_valid = 4'b0011;
      cyc_chk("sat_a", 4'b0001, 16'hFFFD);
      cyc_chk("sat_b", 4'b0010, 16'hFFFE);
      cyc_chk("sat_c", 4'b0001, 16'hFFFF);
      cyc_chk("sat_d", 4'b0010, 16'hFFFF);
      t_valid = '0;
      cyc_chk("sat_e", 4'b0000, 16'hFFFF);

      repeat (3) @(negedge clk);
      chk("queue empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
